// File: rtl/reset_seq_pkg.sv
// Shared definitions for the reset sequencer: FSM state encoding, reset-cause
// codes and a small helper describing the legal release ordering of domains.
package reset_seq_pkg;

    // Sequencer states (3-bit encoding shared with software-visible debug)
    typedef enum logic [2:0] {
        S_SYNC   = 3'd0,
        S_BUS    = 3'd1,
        S_PERIPH = 3'd2,
        S_CPU    = 3'd3,
        S_RUN    = 3'd4,
        S_SOFT   = 3'd5
    } state_t;

    // Cause of the most recent reset, as reported on rst_cause
    localparam logic [1:0] RST_CAUSE_POR  = 2'b00;
    localparam logic [1:0] RST_CAUSE_LOCK = 2'b01;
    localparam logic [1:0] RST_CAUSE_SOFT = 2'b10;
    localparam logic [1:0] RST_CAUSE_RSVD = 2'b11;

    // A later domain may only be out of reset when every earlier one is too.
    // Arguments are the active-low resets, so 1 means "released".
    function automatic logic order_ok(input logic bus_n,
                                      input logic periph_n,
                                      input logic cpu_n);
        logic ok;
        ok = 1'b1;
        if (periph_n && !bus_n) begin
            ok = 1'b0;
        end else if (cpu_n && !periph_n) begin
            ok = 1'b0;
        end else begin
            ok = 1'b1;
        end
        return ok;
    endfunction

endpackage

// File: rtl/reset_seq_chk.sv
// Run-time checks for the reset sequencer outputs. Holds no design state;
// it only observes the registered outputs of reset_seq.
module reset_seq_chk
    import reset_seq_pkg::*;
(
    input logic       clk,
    input logic       reset,
    input logic       bus_reset_,
    input logic       periph_reset_,
    input logic       cpu_reset_,
    input logic       rst_done,
    input logic [1:0] rst_cause
);

    // Domains must never come out of reset ahead of their predecessor
    a_order: assert property (@(posedge clk) disable iff (!reset)
        order_ok(bus_reset_, periph_reset_, cpu_reset_))
        else $error("reset_seq_chk: release order violated");

    // rst_done tracks the last domain release exactly
    a_done: assert property (@(posedge clk) disable iff (!reset)
        (rst_done == cpu_reset_))
        else $error("reset_seq_chk: rst_done inconsistent with cpu_reset_");

    // The reserved cause code is never produced
    a_cause: assert property (@(posedge clk) disable iff (!reset)
        (rst_cause != RST_CAUSE_RSVD))
        else $error("reset_seq_chk: reserved reset cause reported");

endmodule

// File: rtl/reset_seq_sync_ff.sv
// Multi-flop synchroniser with asynchronous active-low clear. Used both for
// reset-deassert synchronisation (input tied high) and for the DCM lock.
module reset_seq_sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] chain_q;

    // Shift the asynchronous input through the chain; clear on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q <= {STAGES{1'b0}};
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/reset_seq.sv
// Reset sequencer: synchronises chip reset release and DCM lock to clk, then
// releases bus, peripheral and CPU resets in order with a fixed gap between
// them. Lock loss and CPU soft-reset requests restart the sequence, and the
// cause of the last reset is kept for software.
module reset_seq
    import reset_seq_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int STAGE_DLY   = 16,
    parameter int SOFT_HOLD   = 8,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       locked,
    input  logic       soft_rst_req,
    output logic       bus_reset_,
    output logic       periph_reset_,
    output logic       cpu_reset_,
    output logic       rst_done,
    output logic [1:0] rst_cause
);

    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_DLY - 1);
    localparam logic [CNT_W-1:0] SOFT_LAST  = CNT_W'(SOFT_HOLD - 1);

    logic             rst_s;
    logic             locked_s;
    logic             lock_lost_s;
    logic [CNT_W-1:0] cnt_d;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             bus_n_q;
    logic             periph_n_q;
    logic             cpu_n_q;
    logic             done_q;
    logic [1:0]       cause_q;

    // Reset deassertion synchroniser: fills with ones after reset rises
    reset_seq_sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_rst_sync (
        .clk   (clk),
        .rst_n (reset),
        .d_i   (1'b1),
        .q_o   (rst_s)
    );

    // DCM lock synchroniser
    reset_seq_sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk   (clk),
        .rst_n (reset),
        .d_i   (locked),
        .q_o   (locked_s)
    );

    // Next counter value and lock-loss detection outside the wait state
    always_comb begin
        cnt_d       = cnt_q + CNT_ONE;
        lock_lost_s = 1'b0;
        if ((state_q != S_SYNC) && !locked_s) begin
            lock_lost_s = 1'b1;
        end else begin
            lock_lost_s = 1'b0;
        end
    end

    // Sequencer FSM with registered domain resets, done flag and cause
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_SYNC;
            cnt_q      <= CNT_ZERO;
            bus_n_q    <= 1'b0;
            periph_n_q <= 1'b0;
            cpu_n_q    <= 1'b0;
            done_q     <= 1'b0;
            cause_q    <= RST_CAUSE_POR;
        end else if (lock_lost_s) begin
            // Lock loss outranks everything, including a same-cycle soft request
            state_q    <= S_SYNC;
            cnt_q      <= CNT_ZERO;
            bus_n_q    <= 1'b0;
            periph_n_q <= 1'b0;
            cpu_n_q    <= 1'b0;
            done_q     <= 1'b0;
            cause_q    <= RST_CAUSE_LOCK;
        end else begin
            case (state_q)
                S_SYNC: begin
                    cnt_q <= CNT_ZERO;
                    if (rst_s && locked_s) begin
                        state_q <= S_BUS;
                    end else begin
                        state_q <= S_SYNC;
                    end
                end
                S_BUS: begin
                    if (cnt_q == STAGE_LAST) begin
                        bus_n_q <= 1'b1;
                        cnt_q   <= CNT_ZERO;
                        state_q <= S_PERIPH;
                    end else begin
                        cnt_q   <= cnt_d;
                    end
                end
                S_PERIPH: begin
                    if (cnt_q == STAGE_LAST) begin
                        periph_n_q <= 1'b1;
                        cnt_q      <= CNT_ZERO;
                        state_q    <= S_CPU;
                    end else begin
                        cnt_q      <= cnt_d;
                    end
                end
                S_CPU: begin
                    if (cnt_q == STAGE_LAST) begin
                        cpu_n_q <= 1'b1;
                        done_q  <= 1'b1;
                        cnt_q   <= CNT_ZERO;
                        state_q <= S_RUN;
                    end else begin
                        cnt_q   <= cnt_d;
                    end
                end
                S_RUN: begin
                    if (soft_rst_req) begin
                        bus_n_q    <= 1'b0;
                        periph_n_q <= 1'b0;
                        cpu_n_q    <= 1'b0;
                        done_q     <= 1'b0;
                        cause_q    <= RST_CAUSE_SOFT;
                        cnt_q      <= CNT_ZERO;
                        state_q    <= S_SOFT;
                    end else begin
                        cnt_q      <= CNT_ZERO;
                    end
                end
                S_SOFT: begin
                    if (cnt_q == SOFT_LAST) begin
                        cnt_q   <= CNT_ZERO;
                        state_q <= S_BUS;
                    end else begin
                        cnt_q   <= cnt_d;
                    end
                end
                default: begin
                    // Unreachable encodings fall back to a safe, fully reset state
                    state_q    <= S_SYNC;
                    cnt_q      <= CNT_ZERO;
                    bus_n_q    <= 1'b0;
                    periph_n_q <= 1'b0;
                    cpu_n_q    <= 1'b0;
                    done_q     <= 1'b0;
                end
            endcase
        end
    end

    assign bus_reset_    = bus_n_q;
    assign periph_reset_ = periph_n_q;
    assign cpu_reset_    = cpu_n_q;
    assign rst_done      = done_q;
    assign rst_cause     = cause_q;

    reset_seq_chk u_chk (
        .clk           (clk),
        .reset         (reset),
        .bus_reset_    (bus_n_q),
        .periph_reset_ (periph_n_q),
        .cpu_reset_    (cpu_n_q),
        .rst_done      (done_q),
        .rst_cause     (cause_q)
    );

endmodule

// File: tb/tb_reset_seq.sv
// Bench for reset_seq. Stimulus pushes each expected output change (edge
// number and value of {bus,periph,cpu,done,cause}) into a queue; a monitor
// on the falling edge pops and compares whenever the outputs change.
module tb_reset_seq;

    logic       clk;
    logic       reset;
    logic       locked;
    logic       soft_rst_req;
    logic       bus_reset_;
    logic       periph_reset_;
    logic       cpu_reset_;
    logic       rst_done;
    logic [1:0] rst_cause;

    typedef struct {
        int         cyc;
        logic [5:0] val;
    } exp_t;

    exp_t       exp_q[$];
    int         cyc;
    int         n_cmp;
    int         n_bad;
    logic [5:0] prev_v;

    reset_seq dut (
        .clk           (clk),
        .reset         (reset),
        .locked        (locked),
        .soft_rst_req  (soft_rst_req),
        .bus_reset_    (bus_reset_),
        .periph_reset_ (periph_reset_),
        .cpu_reset_    (cpu_reset_),
        .rst_done      (rst_done),
        .rst_cause     (rst_cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [5:0] outs();
        return {bus_reset_, periph_reset_, cpu_reset_, rst_done, rst_cause};
    endfunction

    task automatic push(input int c, input logic [5:0] v);
        exp_t e;
        e.cyc = c;
        e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_now(input string name, input logic [5:0] v);
        n_cmp++;
        if (outs() !== v) begin
            n_bad++;
            $display("FAIL %s: got %b want %b at cycle %0d", name, outs(), v, cyc);
        end
    endtask

    // Monitor: every change of the output tuple must match the next expectation
    initial prev_v = 6'b000000;
    always @(negedge clk) begin
        logic [5:0] cur;
        exp_t       e;
        cur = outs();
        if (cur !== prev_v) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_change: got %b at cycle %0d, none expected", cur, cyc);
            end else begin
                e = exp_q.pop_front();
                if ((e.cyc != cyc) || (e.val !== cur)) begin
                    n_bad++;
                    $display("FAIL sb_event: got %b at cycle %0d want %b at cycle %0d",
                             cur, cyc, e.val, e.cyc);
                end
            end
            prev_v = cur;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0;
        int cs;
        int cl;
        int lr;
        n_cmp        = 0;
        n_bad        = 0;
        reset        = 1'b1;
        locked       = 1'b1;
        soft_rst_req = 1'b0;
        #2 reset = 1'b0;
        wait_neg(3);
        check_now("reset_state", 6'b000000);

        // Power-on release with lock stable
        c0 = cyc;
        reset = 1'b1;
        push(c0 + 19, 6'b100000);
        push(c0 + 35, 6'b110000);
        push(c0 + 51, 6'b111100);
        wait_neg(55);
        check_now("run_por", 6'b111100);

        // Soft reset request from S_RUN
        cs = cyc;
        soft_rst_req = 1'b1;
        push(cs + 1,  6'b000010);
        push(cs + 25, 6'b100010);
        push(cs + 41, 6'b110010);
        push(cs + 57, 6'b111110);
        wait_neg(1);
        soft_rst_req = 1'b0;
        wait_neg(59);
        check_now("run_soft", 6'b111110);

        // Lock drop; soft request lands in the same cycle the FSM sees it
        cl = cyc;
        locked = 1'b0;
        push(cl + 3, 6'b000001);
        wait_neg(2);
        soft_rst_req = 1'b1;
        wait_neg(1);
        soft_rst_req = 1'b0;
        wait_neg(7);
        check_now("lock_low_hold", 6'b000001);

        // Lock returns; drop it again one cycle after bus release
        lr = cyc;
        locked = 1'b1;
        push(lr + 19, 6'b100001);
        push(lr + 23, 6'b000001);
        wait_neg(20);
        locked = 1'b0;
        wait_neg(10);

        // Lock returns; soft request during S_PERIPH must be ignored
        lr = cyc;
        locked = 1'b1;
        push(lr + 19, 6'b100001);
        push(lr + 35, 6'b110001);
        push(lr + 51, 6'b111101);
        wait_neg(25);
        soft_rst_req = 1'b1;
        wait_neg(1);
        soft_rst_req = 1'b0;
        wait_neg(30);
        check_now("run_lock_cause", 6'b111101);

        // Soft reset, then async reset between edges while in S_CPU
        cs = cyc;
        soft_rst_req = 1'b1;
        push(cs + 1,  6'b000010);
        push(cs + 25, 6'b100010);
        push(cs + 41, 6'b110010);
        wait_neg(1);
        soft_rst_req = 1'b0;
        wait_neg(44);
        @(posedge clk);
        #2;
        push(cyc, 6'b000000);
        reset = 1'b0;
        #1;
        check_now("async_clear", 6'b000000);
        wait_neg(4);

        // Full power-on timing repeats after the async reset
        c0 = cyc;
        reset = 1'b1;
        push(c0 + 19, 6'b100000);
        push(c0 + 35, 6'b110000);
        push(c0 + 51, 6'b111100);
        wait_neg(55);

        // Late lock: reset with lock low, lock rises well after reset release
        @(posedge clk);
        #2;
        push(cyc, 6'b000000);
        reset  = 1'b0;
        locked = 1'b0;
        wait_neg(3);
        c0 = cyc;
        reset = 1'b1;
        wait_neg(37);
        check_now("late_lock_hold", 6'b000000);
        lr = cyc;
        locked = 1'b1;
        push(lr + 19, 6'b100000);
        push(lr + 35, 6'b110000);
        push(lr + 51, 6'b111100);
        wait_neg(55);
        check_now("run_late_lock", 6'b111100);

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL pending_events: got %0d left want 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
